// File: rtl/pkg_contador_ud.sv
// Shared types and default sizes for the up/down ping-pong counter monitor.
package pkg_contador_ud;

    localparam int LARGURA_PAD   = 4;
    localparam int LARG_CONT_PAD = 8;

    // AQUISICAO: searching for lock
    // SUBINDO:   ascending, next sample is v+1
    // TOPO:      first MAX accepted, waiting for the MAX dwell
    // DESCENDO:  descending, next sample is v-1
    // BASE:      first 0 accepted, waiting for the 0 dwell
    typedef enum logic [2:0] {
        AQUISICAO,
        SUBINDO,
        TOPO,
        DESCENDO,
        BASE
    } estado_t;

endpackage

// File: rtl/contador_saturado.sv
// Event counter that holds at all-ones instead of wrapping, with synchronous clear.
module contador_saturado #(
    parameter int LARG_CONT = 8
) (
    input  logic                 clock,
    input  logic                 limpar,
    input  logic                 incrementa,
    output logic [LARG_CONT-1:0] valor
);

    // Clear has priority; an increment arriving at all-ones is dropped.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (limpar) begin
            valor <= '0;
        end else if (incrementa && (valor != '1)) begin
            valor <= valor + LARG_CONT'(1);
        end
    end

endmodule

// File: rtl/monitor_contador_ud.sv
// Sequence checker for the 4-bit ping-pong counter: locks onto the triangular
// sequence 0,0,1..MAX,MAX,MAX-1..1 and reports lock, direction, dwell events and errors.
module monitor_contador_ud
    import pkg_contador_ud::*;
#(
    parameter int LARGURA   = LARGURA_PAD,
    parameter int LARG_CONT = LARG_CONT_PAD
) (
    input  logic                 clock,
    input  logic                 resert,
    input  logic [LARGURA-1:0]   entrada,
    output logic                 travado,
    output logic                 sentido,
    output logic                 pico,
    output logic                 vale,
    output logic                 erro,
    output logic [LARG_CONT-1:0] periodos,
    output logic [LARG_CONT-1:0] num_erros
);

    localparam logic [LARGURA-1:0] MAX  = '1;
    localparam logic [LARGURA-1:0] ZERO = '0;

    estado_t              estado, estado_nxt;
    logic [LARGURA-1:0]   anterior;
    logic                 tem_amostra;
    logic [LARGURA-1:0]   esperado, esperado_nxt;
    logic                 pico_nxt, vale_nxt, erro_nxt;

    // Neighbours of the previous and current sample; wrap is excluded by the
    // explicit MAX/ZERO guards where these are used.
    logic [LARGURA-1:0]   ant_mais, ant_menos, ent_mais, ent_menos;

    assign ant_mais  = anterior + LARGURA'(1);
    assign ant_menos = anterior - LARGURA'(1);
    assign ent_mais  = entrada  + LARGURA'(1);
    assign ent_menos = entrada  - LARGURA'(1);

    // Next-state, next-expected-sample and pulse decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        estado_nxt   = estado;
        esperado_nxt = esperado;
        pico_nxt     = 1'b0;
        vale_nxt     = 1'b0;
        erro_nxt     = 1'b0;

        if (estado == AQUISICAO) begin
            // The first sample after reset is only stored; never flag errors here.
            if (tem_amostra) begin
                if ((anterior != MAX) && (entrada == ant_mais)) begin
                    if (entrada == MAX) begin
                        estado_nxt   = TOPO;
                        esperado_nxt = MAX;
                    end else begin
                        estado_nxt   = SUBINDO;
                        esperado_nxt = ent_mais;
                    end
                end else if ((anterior != ZERO) && (entrada == ant_menos)) begin
                    if (entrada == ZERO) begin
                        estado_nxt   = BASE;
                        esperado_nxt = ZERO;
                    end else begin
                        estado_nxt   = DESCENDO;
                        esperado_nxt = ent_menos;
                    end
                end else if ((anterior == MAX) && (entrada == MAX)) begin
                    // Lock straight into the descent; the dwell itself is not reported.
                    estado_nxt   = DESCENDO;
                    esperado_nxt = MAX - LARGURA'(1);
                end else if ((anterior == ZERO) && (entrada == ZERO)) begin
                    estado_nxt   = SUBINDO;
                    esperado_nxt = LARGURA'(1);
                end
            end
        end else if (entrada != esperado) begin
            // Error wins over any relock; relock is judged from this sample next edge.
            estado_nxt = AQUISICAO;
            erro_nxt   = 1'b1;
        end else begin
            unique case (estado)
                SUBINDO: begin
                    if (entrada == MAX) begin
                        estado_nxt   = TOPO;
                        esperado_nxt = MAX;
                    end else begin
                        esperado_nxt = ent_mais;
                    end
                end
                TOPO: begin
                    estado_nxt   = DESCENDO;
                    esperado_nxt = ent_menos;
                    pico_nxt     = 1'b1;
                end
                DESCENDO: begin
                    if (entrada == ZERO) begin
                        estado_nxt   = BASE;
                        esperado_nxt = ZERO;
                    end else begin
                        esperado_nxt = ent_menos;
                    end
                end
                BASE: begin
                    estado_nxt   = SUBINDO;
                    esperado_nxt = ent_mais;
                    vale_nxt     = 1'b1;
                end
                default: begin
                    estado_nxt = AQUISICAO;
                end
            endcase
        end
    end

    // State, sample history and registered status outputs.
    always_ff @(posedge clock) begin
        if (resert) begin
            estado      <= AQUISICAO;
            anterior    <= '0;
            tem_amostra <= 1'b0;
            esperado    <= '0;
            travado     <= 1'b0;
            sentido     <= 1'b0;
            pico        <= 1'b0;
            vale        <= 1'b0;
            erro        <= 1'b0;
        end else begin
            estado      <= estado_nxt;
            anterior    <= entrada;
            tem_amostra <= 1'b1;
            esperado    <= esperado_nxt;
            travado     <= (estado_nxt != AQUISICAO);
            sentido     <= (estado_nxt == DESCENDO) || (estado_nxt == TOPO);
            pico        <= pico_nxt;
            vale        <= vale_nxt;
            erro        <= erro_nxt;
        end
    end

    contador_saturado #(
        .LARG_CONT (LARG_CONT)
    ) u_periodos (
        .clock      (clock),
        .limpar     (resert),
        .incrementa (vale_nxt),
        .valor      (periodos)
    );

    contador_saturado #(
        .LARG_CONT (LARG_CONT)
    ) u_num_erros (
        .clock      (clock),
        .limpar     (resert),
        .incrementa (erro_nxt),
        .valor      (num_erros)
    );

endmodule

// File: tb/tb_monitor_contador_ud.sv
// Directed bench for monitor_contador_ud with hand-computed expectations.
module tb_monitor_contador_ud;

    logic       clock;
    logic       resert;
    logic [3:0] entrada;
    logic       travado, sentido, pico, vale, erro;
    logic [7:0] periodos, num_erros;

    int total = 0;
    int bad   = 0;
    int n_pico, n_vale, n_erro, n_both;

    monitor_contador_ud #(
        .LARGURA   (4),
        .LARG_CONT (8)
    ) dut (
        .clock     (clock),
        .resert    (resert),
        .entrada   (entrada),
        .travado   (travado),
        .sentido   (sentido),
        .pico      (pico),
        .vale      (vale),
        .erro      (erro),
        .periodos  (periodos),
        .num_erros (num_erros)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one sample, let it be taken on the next rising edge, then tally pulses.
    task automatic passo(input logic [3:0] v);
        entrada = v;
        @(posedge clock);
        #1;
        if (pico) n_pico++;
        if (vale) n_vale++;
        if (erro) n_erro++;
        if (pico && vale) n_both++;
    endtask

    task automatic zera_contagem();
        n_pico = 0;
        n_vale = 0;
        n_erro = 0;
        n_both = 0;
    endtask

    // Reference ping-pong sequence: 0,0,1..15,15,14..1 repeating every 32 samples.
    function automatic logic [3:0] ref_val(input int i);
        int j;
        j = i % 32;
        if (j < 2)        return 4'd0;
        else if (j <= 16) return 4'(j - 1);
        else              return 4'(32 - j);
    endfunction

    initial begin
        resert  = 1'b1;
        entrada = 4'd0;
        zera_contagem();
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_travado",   travado,   0);
        check("rst_sentido",   sentido,   0);
        check("rst_pulsos",    {pico, vale, erro}, 0);
        check("rst_periodos",  periodos,  0);
        check("rst_num_erros", num_erros, 0);
        resert = 1'b0;

        // Reference sequence: three full periods plus the next 0,0 dwell.
        for (int i = 0; i < 98; i++) begin
            passo(ref_val(i));
            if (i == 0)  check("ref_sem_trava_1a", travado, 0);
            if (i == 1)  check("ref_trava_2a",     travado, 1);
            if (i == 10) check("ref_sentido_sobe", sentido, 0);
            if (i == 20) check("ref_sentido_desce", sentido, 1);
        end
        check("ref_pico_n",   n_pico,   3);
        check("ref_vale_n",   n_vale,   3);
        check("ref_erro_n",   n_erro,   0);
        check("ref_pico_vale_juntos", n_both, 0);
        check("ref_periodos", periodos, 3);
        check("ref_travado",  travado,  1);

        // Ascending up to 8, then 7 instead of 9.
        for (int v = 1; v <= 8; v++) passo(4'(v));
        check("sobe8_travado", travado, 1);
        check("sobe8_sentido", sentido, 0);
        passo(4'd7);
        check("desvio_erro",      erro,      1);
        check("desvio_travado",   travado,   0);
        check("desvio_num_erros", num_erros, 1);
        passo(4'd6);
        check("retrava6_erro",    erro,    0);
        check("retrava6_travado", travado, 1);
        passo(4'd5);
        check("retrava5_travado", travado, 1);
        check("retrava5_sentido", sentido, 1);

        // 6 breaks the descent; 7 relocks ascending; 14,15,14 misses the dwell.
        passo(4'd6);
        check("subida_erro",      erro,      1);
        check("subida_num_erros", num_erros, 2);
        zera_contagem();
        for (int v = 7; v <= 15; v++) passo(4'(v));
        check("antes_dwell_travado", travado, 1);
        check("antes_dwell_erro_n",  n_erro,  0);
        passo(4'd14);
        check("dwell_erro",      erro,      1);
        check("dwell_num_erros", num_erros, 3);
        check("dwell_travado",   travado,   0);
        check("dwell_pico",      n_pico,    0);
        passo(4'd13);
        check("pos_dwell_travado", travado, 1);
        check("pos_dwell_sentido", sentido, 1);
        check("pos_dwell_erro",    erro,    0);
        check("pre_rst_periodos",  periodos, 3);

        // One-cycle reset while locked with nonzero counters.
        resert  = 1'b1;
        entrada = 4'd12;
        @(posedge clock);
        #1;
        check("rst2_travado",   travado,   0);
        check("rst2_sentido",   sentido,   0);
        check("rst2_periodos",  periodos,  0);
        check("rst2_num_erros", num_erros, 0);
        resert = 1'b0;
        passo(4'd10);
        check("meio_10_travado", travado, 0);
        passo(4'd9);
        check("meio_9_travado", travado, 1);
        check("meio_9_sentido", sentido, 1);

        // Fresh acquisition: 15,0,15 are not steps and must not lock or flag.
        resert = 1'b1;
        @(posedge clock);
        #1;
        resert = 1'b0;
        zera_contagem();
        passo(4'd15);
        passo(4'd0);
        check("wrap_15_0_travado", travado, 0);
        passo(4'd15);
        check("wrap_0_15_travado", travado, 0);
        check("wrap_erro_n",       n_erro,  0);
        check("wrap_num_erros",    num_erros, 0);

        // Repeated errors: 3 breaks lock, 12 and 4 acquire, 5 relocks.
        passo(4'd4);
        passo(4'd5);
        check("sat_trava_inicial", travado, 1);
        zera_contagem();
        for (int i = 0; i < 300; i++) begin
            passo(4'd3);
            if (i == 253) check("sat_254", num_erros, 254);
            if (i == 254) check("sat_255", num_erros, 255);
            passo(4'd12);
            passo(4'd4);
            passo(4'd5);
        end
        check("sat_final_num_erros", num_erros, 255);
        check("sat_erro_pulsos",     n_erro,    300);
        check("sat_travado",         travado,   1);
        check("sat_periodos",        periodos,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
